// File: rtl/kt_pkg.sv
// Shared types and constants for the 5x5 knight's tour stream checker.
package kt_pkg;

  localparam int unsigned DEF_BOARD    = 5;
  localparam int unsigned DEF_TOUR_LEN = 25;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StReport
  } kt_state_e;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_OFFBOARD = 3'd1;
  localparam logic [2:0] ERR_MOVE     = 3'd2;
  localparam logic [2:0] ERR_REVISIT  = 3'd3;
  localparam logic [2:0] ERR_INDEX    = 3'd4;
  localparam logic [2:0] ERR_SHORT    = 3'd5;
  localparam logic [2:0] ERR_LONG     = 3'd6;

  // Knight direction encoding: 0=(-1,+2) 1=(+1,+2) 2=(+2,+1) 3=(+2,-1)
  //                            4=(+1,-2) 5=(-1,-2) 6=(-2,-1) 7=(-2,+1)
  function automatic logic signed [3:0] kt_dir_dx(input logic [2:0] dir);
    logic signed [3:0] dx;
    unique case (dir)
      3'd0, 3'd5: dx = -4'sd1;
      3'd1, 3'd4: dx = 4'sd1;
      3'd2, 3'd3: dx = 4'sd2;
      default:    dx = -4'sd2;
    endcase
    return dx;
  endfunction

  function automatic logic signed [3:0] kt_dir_dy(input logic [2:0] dir);
    logic signed [3:0] dy;
    unique case (dir)
      3'd0, 3'd1: dy = 4'sd2;
      3'd2, 3'd7: dy = 4'sd1;
      3'd3, 3'd6: dy = -4'sd1;
      default:    dy = -4'sd2;
    endcase
    return dy;
  endfunction

  // Step numbers are reported in 5 bits and saturate at 31.
  function automatic logic [4:0] sat_step(input logic [5:0] n);
    return (n > 6'd31) ? 5'd31 : n[4:0];
  endfunction

endpackage

// File: rtl/kt_move_legal.sv
// Combinational square/step classifier: on-board test and knight-step test.
module kt_move_legal
  import kt_pkg::*;
#(
  parameter int unsigned BOARD = DEF_BOARD
) (
  input  logic [2:0] prev_x,
  input  logic [2:0] prev_y,
  input  logic [2:0] cur_x,
  input  logic [2:0] cur_y,
  output logic       on_board,
  output logic       is_knight
);

  localparam logic [3:0] BoardW = 4'(BOARD);

  logic signed [3:0] dx, dy;
  logic        [3:0] adx, ady;

  // Signed deltas, their magnitudes, and the {1,2} knight pattern.
  always_comb begin
    dx        = $signed({1'b0, cur_x}) - $signed({1'b0, prev_x});
    dy        = $signed({1'b0, cur_y}) - $signed({1'b0, prev_y});
    adx       = dx[3] ? 4'(-dx) : 4'(dx);
    ady       = dy[3] ? 4'(-dy) : 4'(dy);
    on_board  = ({1'b0, cur_x} < BoardW) && ({1'b0, cur_y} < BoardW);
    is_knight = ((adx == 4'd1) && (ady == 4'd2)) || ((adx == 4'd2) && (ady == 4'd1));
  end

endmodule

// File: rtl/kt_tour_checker.sv
// Streaming knight's tour checker: latches the first error of a stream and
// reports a one-cycle verdict two edges after the last beat.
module kt_tour_checker
  import kt_pkg::*;
#(
  parameter int unsigned BOARD    = DEF_BOARD,
  parameter int unsigned TOUR_LEN = DEF_TOUR_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_x,
  input  logic [2:0] in_y,
  input  logic [4:0] move_in,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_code,
  output logic [4:0] err_step
);

  localparam int unsigned IdxW  = $clog2(TOUR_LEN);
  localparam logic [5:0]  TourW = 6'(TOUR_LEN);

  kt_state_e            state_q, state_d;
  logic [5:0]           beat_cnt_q, beat_cnt_d;
  logic [TOUR_LEN-1:0]  visited_q, visited_d;
  logic [2:0]           prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic                 prev_ok_q, prev_ok_d;
  logic [2:0]           err_code_q, err_code_d;
  logic [4:0]           err_step_q, err_step_d;
  // Verdict captured on entry to REPORT, presented one edge later.
  logic                 v_pass_q, v_pass_d;
  logic [2:0]           v_code_q, v_code_d;
  logic [4:0]           v_step_q, v_step_d;

  logic                 on_board, is_knight;
  logic [5:0]           beat_num;
  logic [IdxW-1:0]      sq_idx;
  logic [2:0]           beat_code;

  kt_move_legal #(
    .BOARD(BOARD)
  ) u_move_legal (
    .prev_x   (prev_x_q),
    .prev_y   (prev_y_q),
    .cur_x    (in_x),
    .cur_y    (in_y),
    .on_board (on_board),
    .is_knight(is_knight)
  );

  // Per-beat classification, highest priority first.
  always_comb begin
    beat_num  = (beat_cnt_q == 6'd63) ? 6'd63 : beat_cnt_q + 6'd1;
    sq_idx    = IdxW'(32'(in_y) * BOARD + 32'(in_x));
    beat_code = ERR_NONE;
    if (beat_num > TourW) begin
      beat_code = ERR_LONG;
    end else if (!on_board) begin
      beat_code = ERR_OFFBOARD;
    end else if ({1'b0, move_in} != beat_num) begin
      beat_code = ERR_INDEX;
    end else if ((beat_num > 6'd1) && prev_ok_q && !is_knight) begin
      beat_code = ERR_MOVE;
    end else if (visited_q[sq_idx]) begin
      beat_code = ERR_REVISIT;
    end
  end

  // Next-state: FSM, beat bookkeeping, first-error latch and verdict capture.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    visited_d  = visited_q;
    prev_x_d   = prev_x_q;
    prev_y_d   = prev_y_q;
    prev_ok_d  = prev_ok_q;
    err_code_d = err_code_q;
    err_step_d = err_step_q;
    v_pass_d   = v_pass_q;
    v_code_d   = v_code_q;
    v_step_d   = v_step_q;

    unique case (state_q)
      StIdle:   if (in_valid) state_d = StCheck;
      StCheck:  if (!in_valid) state_d = StReport;
      StReport: state_d = in_valid ? StCheck : StIdle;
      default:  state_d = StIdle;
    endcase

    if (state_q == StCheck && !in_valid) begin
      v_pass_d = 1'b0;
      v_code_d = err_code_q;
      v_step_d = err_step_q;
      if (err_code_q == ERR_NONE) begin
        if (beat_cnt_q < TourW) begin
          v_code_d = ERR_SHORT;
          v_step_d = sat_step(beat_cnt_q + 6'd1);
        end else if (beat_cnt_q > TourW) begin
          v_code_d = ERR_LONG;
          v_step_d = sat_step(TourW + 6'd1);
        end else begin
          v_pass_d = 1'b1;
          v_step_d = 5'd0;
        end
      end
      visited_d  = '0;
      beat_cnt_d = '0;
      prev_ok_d  = 1'b0;
      err_code_d = ERR_NONE;
      err_step_d = '0;
    end else if (in_valid) begin
      beat_cnt_d = beat_num;
      if (on_board) begin
        visited_d[sq_idx] = 1'b1;
        prev_x_d          = in_x;
        prev_y_d          = in_y;
        prev_ok_d         = 1'b1;
      end
      if (err_code_q == ERR_NONE && beat_code != ERR_NONE) begin
        err_code_d = beat_code;
        err_step_d = sat_step(beat_num);
      end
    end
  end

  // Internal state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      visited_q  <= '0;
      prev_x_q   <= '0;
      prev_y_q   <= '0;
      prev_ok_q  <= 1'b0;
      err_code_q <= ERR_NONE;
      err_step_q <= '0;
      v_pass_q   <= 1'b0;
      v_code_q   <= ERR_NONE;
      v_step_q   <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      visited_q  <= visited_d;
      prev_x_q   <= prev_x_d;
      prev_y_q   <= prev_y_d;
      prev_ok_q  <= prev_ok_d;
      err_code_q <= err_code_d;
      err_step_q <= err_step_d;
      v_pass_q   <= v_pass_d;
      v_code_q   <= v_code_d;
      v_step_q   <= v_step_d;
    end
  end

  // Registered outputs: verdict fields are non-zero only in the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      pass     <= 1'b0;
      err_code <= ERR_NONE;
      err_step <= '0;
    end else begin
      done     <= (state_q == StReport);
      pass     <= (state_q == StReport) & v_pass_q;
      err_code <= (state_q == StReport) ? v_code_q : ERR_NONE;
      err_step <= (state_q == StReport) ? v_step_q : 5'd0;
    end
  end

endmodule

// File: doc/kt_tour_checker.md
# kt_tour_checker

Streaming checker for 5x5 knight's tours. Consumes the position stream a tour solver emits (`valid`, `x`, `y`, move index) and checks five properties: every square is on the board, every step is a legal knight move, no square is revisited, move indices are sequential, and the stream length is correct. After the stream ends it reports a single pass/fail verdict, the first error code and the step where that error occurred. It sits on the solver's output interface as the receiving end, both in the verification harness and as an on-chip self-check.

## Interface
- `BOARD`, default 5: board edge length; legal coordinates are 0..BOARD-1.
- `TOUR_LEN`, default 25: beats in a complete tour (BOARD*BOARD).
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset; asynchronous, active-low.
- `in_valid`, input, 1: beat qualifier. A stream is one contiguous run of high cycles.
- `in_x`, input, 3: column of this beat.
- `in_y`, input, 3: row of this beat.
- `move_in`, input, 5: move index claimed by the sender; 1 for the first beat.
- `done`, output, 1: one-cycle pulse carrying the verdict.
- `pass`, output, 1: 1 if the stream had no error; valid only while `done` is high, 0 otherwise.
- `err_code`, output, 3: first error found (codes below); 0 unless `done` is high.
- `err_step`, output, 5: 1-based beat number of the first error; 0 on pass and 0 unless `done` is high.

## Operation
- States: `IDLE`, `CHECK`, `REPORT`.
  - `IDLE` goes to `CHECK` on `in_valid`; that beat is beat 1.
  - `CHECK` stays while `in_valid` is high.
  - The first sampled `in_valid=0` in `CHECK` goes to `REPORT`.
  - `REPORT` lasts one cycle, then goes to `IDLE`. If `in_valid` is high during `REPORT`, that beat is beat 1 of a new stream and the next state is `CHECK`.
- `beat_cnt` (6 bits) counts accepted beats and saturates at 63.
- `visited[TOUR_LEN-1:0]` is a bitmap. Bit `y*BOARD+x` is set for each on-board beat. The previous on-board position is held in `prev_x`/`prev_y` with a `prev_ok` flag.
- Per-beat checks, listed in priority order. Only the highest-priority failing check on a beat is reported.
  - Code 1, off-board: `in_x>=BOARD` or `in_y>=BOARD`. An off-board beat does not update the bitmap or the previous position.
  - Code 4, bad index: `move_in != beat_cnt+1` (beat number, 1-based).
  - Code 2, illegal move: beat number > 1, `prev_ok`, and {|dx|,|dy|} is not {1,2} in either order. Use 4-bit signed deltas.
  - Code 3, revisit: the bitmap bit for this square is already set.
- End-of-stream checks, evaluated on entry to `REPORT`. These apply only if no per-beat error was latched.
  - Code 5, short: `beat_cnt<TOUR_LEN`; `err_step` = `beat_cnt+1`.
  - Code 6, long: `beat_cnt>TOUR_LEN`; `err_step` = `TOUR_LEN+1`. The per-beat path also latches code 6 at beat TOUR_LEN+1 if nothing earlier was latched, so the end-of-stream check is a backstop.
- Only the first error is latched; checking continues until the stream ends. `err_step` saturates at 31.
- On entry to `REPORT`: clear the bitmap, `beat_cnt`, `prev_ok` and the error latch. A stream starting in the `REPORT` cycle therefore checks cleanly.
- `pass` = 1 iff the latched code is 0 and `beat_cnt==TOUR_LEN`.

## Timing
- Reset values: `done`, `pass`, `err_code` and `err_step` all 0; state `IDLE`; bitmap, counters and error latch cleared.
- Beats are accepted every cycle with no backpressure.
- Latency: the last beat is at edge N and `in_valid=0` is sampled at edge N+1. `done`, `pass`, `err_code` and `err_step` are registered and high/valid for exactly the cycle after edge N+2. Total is 2 edges after the last beat.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-stream aborts the stream with no `done`. The first high `in_valid` after reset is beat 1.

## Structure
- Package `kt_pkg` holds:
  - `BOARD`, `TOUR_LEN` defaults;
  - the state enum;
  - error-code localparams `ERR_NONE=0`, `ERR_OFFBOARD=1`, `ERR_MOVE=2`, `ERR_REVISIT=3`, `ERR_INDEX=4`, `ERR_SHORT=5`, `ERR_LONG=6`;
  - the knight direction encoding 0..7, where 0=(-1,+2), 1=(+1,+2), 2=(+2,+1), 3=(+2,-1), 4=(+1,-2), 5=(-1,-2), 6=(-2,-1), 7=(-2,+1).
- One sub-module, `kt_move_legal`: combinational; inputs are the previous and current coordinates, outputs are `on_board` and `is_knight`.

## Test plan
- Valid tour of 25 beats from (0,0) with `move_in` 1..25 → `done` 2 cycles after the last beat, `pass=1`, `err_code=0`, `err_step=0`.
- Same tour with beat 10 replaced by the beat-4 square, knight-reachable from beat 9 → `pass=0`, `err_code=3`, `err_step=10`.
- Beat 1 = (5,0) → `err_code=1`, `err_step=1`. Beat 5 is a (+1,+1) step → `err_code=2`, `err_step=5`.
- Valid tour with `move_in` on beat 7 = 8 → `err_code=4`, `err_step=7`.
  - Same tour truncated to 24 beats → `err_code=5`, `err_step=25`.
  - 26 beats → `err_code=6`, `err_step=26`.
- `rst_n` pulsed low at beat 12, then a full valid tour → exactly one `done`, with `pass=1`. A second tour whose beat 1 falls in the `REPORT` cycle of the first → two `done` pulses, both with `pass=1`.
